// File: rtl/sdram_write_arbiter.sv
// sdram_write_arbiter
//   Shares one SDRAM Avalon-MM write master between two filter-engine write
//   ports. Round-robin arbitration; a grant is held for at most HOLD_MAX
//   accepted beats while the other requester is waiting. Address and data
//   pass straight through from the granted requester (no buffering).
//
//   Ports
//     clk, reset_n                       clock, async active-low reset
//     r0_write/address/writedata         requester 0 Avalon slave inputs
//     r0_waitrequest                     requester 0 stall
//     r1_*                               same for requester 1
//     sdaddress/sdwrite/sdwritedata      SDRAM master outputs
//     sdwaitrequest                      SDRAM stall
//     grant                              one-hot grant, 2'b00 when idle
//
//   Optional feature (macro ARB_STATS_EN): saturating beat/stall counters
//     stat_clear (in), stat_beats0/stat_beats1/stat_stall (out, 32 bit).
//
//   state | meaning
//   IDLE  | no grant, both requesters stalled
//   G0    | requester 0 owns the SDRAM master
//   G1    | requester 1 owns the SDRAM master
module sdram_write_arbiter #(
   parameter int ADDR_W   = 24,
   parameter int DATA_W   = 32,
   parameter int HOLD_MAX = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              r0_write,
   input  logic [ADDR_W-1:0] r0_address,
   input  logic [DATA_W-1:0] r0_writedata,
   output logic              r0_waitrequest,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_address,
   input  logic [DATA_W-1:0] r1_writedata,
   output logic              r1_waitrequest,
   output logic [ADDR_W-1:0] sdaddress,
   output logic              sdwrite,
   output logic [DATA_W-1:0] sdwritedata,
   input  logic              sdwaitrequest,
   output logic [1:0]        grant
`ifdef ARB_STATS_EN
   ,
   input  logic              stat_clear,
   output logic [31:0]       stat_beats0,
   output logic [31:0]       stat_beats1,
   output logic [31:0]       stat_stall
`endif
);

   localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G0   = 2'd1,
      ST_G1   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic beat_acc;
   logic cur_idx;
   logic own_write;
   logic oth_write;

   // Master side is a pure mux of the current owner so that the Avalon hold
   // rule is inherited directly from the requester's own hold behaviour.
   always_comb begin
      grant          = 2'b00;
      sdwrite        = 1'b0;
      sdaddress      = '0;
      sdwritedata    = '0;
      r0_waitrequest = 1'b1;
      r1_waitrequest = 1'b1;
      case (state_q)
         ST_G0: begin
            grant          = 2'b01;
            sdwrite        = r0_write;
            sdaddress      = r0_address;
            sdwritedata    = r0_writedata;
            r0_waitrequest = sdwaitrequest;
         end
         ST_G1: begin
            grant          = 2'b10;
            sdwrite        = r1_write;
            sdaddress      = r1_address;
            sdwritedata    = r1_writedata;
            r1_waitrequest = sdwaitrequest;
         end
         default: ;
      endcase
   end

   assign beat_acc  = sdwrite & ~sdwaitrequest;
   assign cur_idx   = (state_q == ST_G1);
   assign own_write = cur_idx ? r1_write : r0_write;
   assign oth_write = cur_idx ? r0_write : r1_write;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (r0_write && (!r1_write || !rr_ptr_q)) begin
               state_d    = ST_G0;
               rr_ptr_d   = 1'b1;
               beat_cnt_d = '0;
            end else if (r1_write) begin
               state_d    = ST_G1;
               rr_ptr_d   = 1'b0;
               beat_cnt_d = '0;
            end
         end
         ST_G0, ST_G1: begin
            // Leaving is only possible when the owner is not presenting a
            // beat, or its last allowed beat is accepted this cycle; either
            // way no stalled write is abandoned.
            if (!own_write || (beat_acc && beat_cnt_q == HOLD_LAST)) begin
               beat_cnt_d = '0;
               if (oth_write) begin
                  state_d  = cur_idx ? ST_G0 : ST_G1;
                  rr_ptr_d = cur_idx;
               end else if (!own_write) begin
                  state_d = ST_IDLE;
               end
            end else if (beat_acc) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [31:0] stat_beats0_q, stat_beats1_q, stat_stall_q;
   logic        acc0, acc1, stall_cyc;

   assign acc0      = beat_acc & (state_q == ST_G0);
   assign acc1      = beat_acc & (state_q == ST_G1);
   assign stall_cyc = (r0_write & r0_waitrequest) | (r1_write & r1_waitrequest);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_beats0_q <= '0;
         stat_beats1_q <= '0;
         stat_stall_q  <= '0;
      end else if (stat_clear) begin
         stat_beats0_q <= '0;
         stat_beats1_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         if (acc0 && stat_beats0_q != '1) stat_beats0_q <= stat_beats0_q + 32'd1;
         if (acc1 && stat_beats1_q != '1) stat_beats1_q <= stat_beats1_q + 32'd1;
         if (stall_cyc && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 32'd1;
      end
   end

   assign stat_beats0 = stat_beats0_q;
   assign stat_beats1 = stat_beats1_q;
   assign stat_stall  = stat_stall_q;
`endif

endmodule
